// File: rtl/proc_test_pkg.sv
// Shared widths, FSM state encoding and port indices for the telescoping filter bank.
package proc_test_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NSTG     = 5;
  localparam int unsigned NBAND    = NSTG + 1;
  localparam int unsigned OUT_EN_W = NSTG + 2;
  localparam int unsigned CNT_W    = 3;

  localparam int unsigned PORT_FIRST_BAND = 1;
  localparam int unsigned PORT_LAST_BAND  = NBAND;

  typedef enum logic [1:0] {
    S_REQ,
    S_CALC,
    S_OUT
  } state_t;

endpackage

// File: rtl/proc_test_00_avg2_stage.sv
// Two-tap averager: sign-extended add then arithmetic shift, i.e. floor((a+b)/2).
module avg2_stage
  import proc_test_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] avg_c
);

  logic signed [DATA_W:0] sum;

  // One guard bit keeps the sum exact; the halved result always fits DATA_W.
  assign sum   = (DATA_W+1)'(a) + (DATA_W+1)'(b);
  assign avg_c = DATA_W'(sum >>> 1);

endmodule

// File: rtl/proc_test_00.sv
// Six-band telescoping filter bank: one input request, five averager updates,
// six band strobes per sample, 12 cycles per sample.
module proc_test_00
  import proc_test_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [DATA_W-1:0]   io_in,
  output logic signed [DATA_W-1:0]   io_out,
  output logic                       req_in,
  output logic [OUT_EN_W-1:0]        out_en
);

  localparam logic [CNT_W-1:0] SEL_FIRST = CNT_W'(PORT_FIRST_BAND);
  localparam logic [CNT_W-1:0] SEL_LAST  = CNT_W'(PORT_LAST_BAND);
  localparam logic [CNT_W-1:0] K_LAST    = CNT_W'(NSTG);

  state_t                    state, state_next;
  logic [CNT_W-1:0]          k, k_next, p, p_next;
  logic [CNT_W-1:0]          sel, stg_idx;
  logic                      req_next, cap, calc;
  logic [OUT_EN_W-1:0]       out_en_next;
  logic signed [DATA_W-1:0]  io_out_next, band_c, avg_c;
  logic signed [DATA_W-1:0]  cur  [NBAND];
  logic signed [DATA_W-1:0]  prev [NSTG];

  assign stg_idx = k - CNT_W'(1);

  avg2_stage u_avg (
    .a     (cur[stg_idx]),
    .b     (prev[stg_idx]),
    .avg_c (avg_c)
  );

  // Port whose band is registered at the coming edge.
  always_comb begin
    sel = SEL_FIRST;
    if (state == S_OUT) sel = p + CNT_W'(1);
  end

  always_comb begin
    band_c = cur[NSTG];
    if (sel != '0 && sel < SEL_LAST) band_c = cur[sel - CNT_W'(1)] - cur[sel];
  end

  always_comb begin
    state_next  = state;
    k_next      = k;
    p_next      = p;
    req_next    = 1'b0;
    out_en_next = '0;
    io_out_next = io_out;
    cap         = 1'b0;
    calc        = 1'b0;
    case (state)
      // req_in low here only right after reset: raise it before capturing.
      S_REQ: begin
        if (req_in) begin
          cap        = 1'b1;
          k_next     = CNT_W'(1);
          state_next = S_CALC;
        end else begin
          req_next = 1'b1;
        end
      end
      S_CALC: begin
        calc = 1'b1;
        if (k == K_LAST) begin
          p_next      = SEL_FIRST;
          state_next  = S_OUT;
          out_en_next = OUT_EN_W'(1) << sel;
          io_out_next = band_c;
        end else begin
          k_next = k + CNT_W'(1);
        end
      end
      S_OUT: begin
        if (p == SEL_LAST) begin
          state_next = S_REQ;
          req_next   = 1'b1;
        end else begin
          p_next      = sel;
          out_en_next = OUT_EN_W'(1) << sel;
          io_out_next = band_c;
        end
      end
      default: state_next = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_REQ;
      k      <= '0;
      p      <= '0;
      req_in <= 1'b0;
      out_en <= '0;
      io_out <= '0;
      for (int i = 0; i < NBAND; i++) cur[i] <= '0;
      for (int i = 0; i < NSTG; i++)  prev[i] <= '0;
    end else begin
      state  <= state_next;
      k      <= k_next;
      p      <= p_next;
      req_in <= req_next;
      out_en <= out_en_next;
      io_out <= io_out_next;
      if (cap) cur[0] <= io_in;
      if (calc) begin
        cur[k]        <= avg_c;
        prev[stg_idx] <= cur[stg_idx];
      end
    end
  end

endmodule

// File: tb/tb_proc_test_00.sv
// Bench for proc_test_00: hand-derived vector table, corner sequences, and
// random samples against a cascade-of-averagers reference model.
module tb_proc_test_00;
  import proc_test_pkg::*;

  typedef longint bands_t [6];
  typedef struct packed {
    logic              rst_first;
    logic signed [31:0] x;
    logic [5:0][31:0]  exp;
  } vec_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic signed [DATA_W-1:0]  io_in = '0;
  logic signed [DATA_W-1:0]  io_out;
  logic                      req_in;
  logic [OUT_EN_W-1:0]       out_en;

  int     vecs = 0;
  int     errs = 0;
  longint last_out = 0;
  longint m_cur  [6];
  longint m_prev [5];

  proc_test_00 dut (
    .clk    (clk),
    .rst    (rst),
    .io_in  (io_in),
    .io_out (io_out),
    .req_in (req_in),
    .out_en (out_en)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) m_cur[i] = 0;
    for (int i = 0; i < 5; i++) m_prev[i] = 0;
  endfunction

  // Each stage averages the current and previous value of the stage before it.
  function automatic bands_t model_step(input longint x);
    bands_t b;
    longint nc;
    m_cur[0] = x;
    for (int s = 1; s < 6; s++) begin
      nc          = (m_cur[s-1] + m_prev[s-1]) >>> 1;
      m_prev[s-1] = m_cur[s-1];
      m_cur[s]    = nc;
    end
    for (int i = 0; i < 5; i++) b[i] = m_cur[i] - m_cur[i+1];
    b[5] = m_cur[5];
    return b;
  endfunction

  function automatic logic [5:0][31:0] mk(input int b1, b2, b3, b4, b5, b6);
    logic [5:0][31:0] r;
    r[0] = 32'(b1); r[1] = 32'(b2); r[2] = 32'(b3);
    r[3] = 32'(b4); r[4] = 32'(b5); r[5] = 32'(b6);
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_req_in", longint'(req_in), 0);
    check("rst_out_en", longint'(out_en), 0);
    check("rst_io_out", longint'(io_out), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("first_req_in", longint'(req_in), 1);
    check("first_out_en", longint'(out_en), 0);
    check("first_io_out", longint'(io_out), 0);
    model_reset();
    last_out = 0;
  endtask

  task automatic wait_req(input bit steady, output bit ok);
    int n = 0;
    while (!req_in && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = req_in;
    if (!ok) check("req_timeout", 0, 1);
    else if (steady) check("period", n, 0);
  endtask

  task automatic run_sample(input longint x, input bit steady, output bands_t got);
    bit ok;
    longint sum = 0;
    for (int i = 0; i < 6; i++) got[i] = 0;
    wait_req(steady, ok);
    if (!ok) return;
    io_in = DATA_W'(x);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      check("req_low", longint'(req_in), 0);
      if (c <= 5) begin
        check("calc_out_en", longint'(out_en), 0);
        check("io_out_hold", longint'(io_out), last_out);
      end else begin
        check("band_out_en", longint'(out_en), longint'(1) << (c - 5));
        got[c-6] = longint'(io_out);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) sum += got[i];
    check("reconstruct", sum, x);
    last_out = got[5];
  endtask

  initial begin
    vec_t   tbl [5];
    bands_t got, exp_b;
    bit     ok;

    tbl[0] = '{1'b1, 32'sd64,  mk(32, 16, 8, 4, 2, 2)};
    tbl[1] = '{1'b0, 32'sd64,  mk(0, 16, 16, 12, 8, 12)};
    tbl[2] = '{1'b1, -32'sd1,  mk(0, 0, 0, 0, 0, -1)};
    tbl[3] = '{1'b1, 32'sd32,  mk(16, 8, 4, 2, 1, 1)};
    tbl[4] = '{1'b0, 32'sd0,   mk(-16, 0, 4, 4, 3, 5)};

    do_reset();
    for (int v = 0; v < 5; v++) begin
      if (tbl[v].rst_first) do_reset();
      exp_b = model_step(longint'(tbl[v].x));
      run_sample(longint'(tbl[v].x), !tbl[v].rst_first, got);
      for (int i = 0; i < 6; i++)
        check($sformatf("tbl%0d_band%0d", v, i + 1), got[i], longint'($signed(tbl[v].exp[i])));
    end

    // Impulse tail: further zeros keep reconstructing to zero.
    for (int s = 0; s < 6; s++) begin
      exp_b = model_step(0);
      run_sample(0, 1'b1, got);
      for (int i = 0; i < 6; i++) check($sformatf("imp%0d_band%0d", s, i + 1), got[i], exp_b[i]);
    end

    do_reset();
    for (int s = 0; s < 1000; s++) begin
      longint x;
      x = longint'($urandom() % 32'h8000_0001) - 64'sd1073741824;
      exp_b = model_step(x);
      run_sample(x, s != 0, got);
      for (int i = 0; i < 6; i++) check($sformatf("rnd%0d_band%0d", s, i + 1), got[i], exp_b[i]);
    end

    // Abort in the middle of the averager updates.
    wait_req(1'b1, ok);
    io_in = DATA_W'(64);
    repeat (2) @(negedge clk);
    do_reset();
    exp_b = model_step(64);
    run_sample(64, 1'b0, got);
    for (int i = 0; i < 6; i++)
      check($sformatf("abort_band%0d", i + 1), got[i], longint'($signed(tbl[0].exp[i])));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
